// File: rtl/apb_master_pkg.sv
// Shared types for the APB command master: FSM states, target select codes
// and the packed command record carried through the command queue.
package apb_master_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  localparam logic [1:0] SEL_NONE = 2'd0;
  localparam logic [1:0] SEL_GPIO = 2'd1;
  localparam logic [1:0] SEL_UART = 2'd2;

  // 40-bit command record: write(1) + sel(2) + addr(5) + wdata(32)
  typedef struct packed {
    logic        write;
    logic [1:0]  sel;
    logic [4:0]  addr;
    logic [31:0] wdata;
  } cmd_t;

  // Only GPIO and UART exist behind the bridge; anything else is rejected.
  function automatic logic sel_is_valid(input logic [1:0] sel);
    return (sel == SEL_GPIO) || (sel == SEL_UART);
  endfunction

endpackage

// File: rtl/apb_cmd_fifo.sv
// Command queue for the APB master. Storage is written on push; an entry only
// becomes visible to the reader one cycle after it was written, so there is
// no same-cycle bypass from push to pop. full/occupied use the true write
// pointer, empty uses the delayed (visible) one.
module apb_cmd_fifo
  import apb_master_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic pclk,
  input  logic rst,
  input  logic push,
  input  cmd_t push_data,
  input  logic pop,
  output cmd_t head,
  output logic full,
  output logic empty,
  output logic occupied
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0] wr_ptr_reg;
  logic [AW:0] rd_ptr_reg;
  logic [AW:0] vis_ptr_reg;
  cmd_t        mem [DEPTH];

  // Pointer bookkeeping; vis_ptr trails wr_ptr by one cycle.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg  <= '0;
      rd_ptr_reg  <= '0;
      vis_ptr_reg <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
      vis_ptr_reg <= wr_ptr_reg;
    end
  end

  // Entry storage; contents need no reset because the pointers qualify them.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr_reg[AW-1:0]] <= push_data;
  end

  assign head     = mem[rd_ptr_reg[AW-1:0]];
  assign full     = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                    (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
  assign empty    = (vis_ptr_reg == rd_ptr_reg);
  assign occupied = (wr_ptr_reg != rd_ptr_reg);

endmodule

// File: rtl/apb_cmd_master.sv
// APB command master: queues commands, runs them one at a time through
// SETUP/ACCESS on the bridge, and returns one response pulse per command in
// acceptance order. Invalid targets skip the bus and respond with an error.
module apb_cmd_master
  import apb_master_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 16
) (
  input  logic        pclk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic        cmd_write,
  input  logic [1:0]  cmd_sel,
  input  logic [4:0]  cmd_addr,
  input  logic [31:0] cmd_wdata,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  psel,
  output logic        transfer,
  output logic        penable,
  output logic        pwrite,
  output logic [4:0]  write_paddr,
  output logic [4:0]  apb_read_paddr,
  output logic [31:0] write_data,
  input  logic        pready,
  input  logic [31:0] prdata,
  output logic        busy
);

  localparam int CW = $clog2(TIMEOUT + 1);

  state_t        state_reg;
  state_t        state_next;
  cmd_t          cmd_reg;
  cmd_t          fifo_head;
  cmd_t          fifo_in;
  logic [CW-1:0] cnt_reg;
  logic [31:0]   rdata_reg;
  logic          err_reg;
  logic          run_reg;
  logic          fifo_push;
  logic          fifo_pop;
  logic          fifo_full;
  logic          fifo_empty;
  logic          fifo_occupied;
  logic          head_valid;
  logic          timeout_hit;

  assign fifo_in     = '{write: cmd_write, sel: cmd_sel, addr: cmd_addr, wdata: cmd_wdata};
  assign fifo_push   = cmd_valid & cmd_ready;
  assign head_valid  = sel_is_valid(fifo_head.sel);
  // Last permitted ACCESS cycle; pready in this same cycle still wins.
  assign timeout_hit = (cnt_reg == CW'(TIMEOUT - 1));

  apb_cmd_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .pclk     (pclk),
    .rst      (rst),
    .push     (fifo_push),
    .push_data(fifo_in),
    .pop      (fifo_pop),
    .head     (fifo_head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .occupied (fifo_occupied)
  );

  // FSM state register.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) state_reg <= ST_IDLE;
    else      state_reg <= state_next;
  end

  // Next-state and pop decision; pops happen only from IDLE or RESP.
  always_comb begin
    state_next = state_reg;
    fifo_pop   = 1'b0;
    case (state_reg)
      ST_IDLE, ST_RESP: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          state_next = head_valid ? ST_SETUP : ST_RESP;
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_SETUP:  state_next = ST_ACCESS;
      ST_ACCESS: if (pready || timeout_hit) state_next = ST_RESP;
      default:   state_next = ST_IDLE;
    endcase
  end

  // Current command, ACCESS wait counter and captured response.
  always_ff @(posedge pclk or negedge rst) begin
    if (!rst) begin
      cmd_reg   <= '0;
      cnt_reg   <= '0;
      rdata_reg <= '0;
      err_reg   <= 1'b0;
      run_reg   <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (fifo_pop) begin
        cmd_reg   <= fifo_head;
        err_reg   <= !head_valid;
        rdata_reg <= '0;
      end
      if (state_reg == ST_SETUP) begin
        cnt_reg <= '0;
      end else if (state_reg == ST_ACCESS) begin
        cnt_reg <= cnt_reg + CW'(1);
        if (pready) begin
          err_reg   <= 1'b0;
          rdata_reg <= cmd_reg.write ? 32'd0 : prdata;
        end else if (timeout_hit) begin
          err_reg   <= 1'b1;
          rdata_reg <= '0;
        end
      end
    end
  end

  // Bus and response outputs decoded from state; everything idles at 0.
  always_comb begin
    psel           = '0;
    transfer       = 1'b0;
    penable        = 1'b0;
    pwrite         = 1'b0;
    write_paddr    = '0;
    apb_read_paddr = '0;
    write_data     = '0;
    rsp_valid      = 1'b0;
    rsp_rdata      = '0;
    rsp_err        = 1'b0;
    case (state_reg)
      ST_SETUP, ST_ACCESS: begin
        psel     = cmd_reg.sel;
        transfer = 1'b1;
        penable  = (state_reg == ST_ACCESS);
        pwrite   = cmd_reg.write;
        if (cmd_reg.write) begin
          write_paddr = cmd_reg.addr;
          write_data  = cmd_reg.wdata;
        end else begin
          apb_read_paddr = cmd_reg.addr;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_rdata = rdata_reg;
        rsp_err   = err_reg;
      end
      default: ;
    endcase
  end

  // run_reg keeps cmd_ready low while reset is held.
  assign cmd_ready = run_reg & ~fifo_full;
  assign busy      = fifo_occupied | (state_reg != ST_IDLE);

endmodule
